// File: rtl/sent_slow_msg_arbiter.sv
// SENT slow-channel message arbiter.
// Round-robin selection among N_SLOTS requesters of serial messages. The
// winning slot's format/config/ID/data are latched and held for the whole
// message, the transmitter is started with a one-cycle enable, completed
// frames are counted, and the slot is acknowledged after its last frame.
// A stalled transmitter (no frame_done for TIMEOUT_CYC cycles) aborts the
// message without an ack and passes the channel on to the next slot.
module sent_slow_msg_arbiter #(
    parameter int N_SLOTS      = 4,
    parameter int FRAMES_SHORT = 16,
    parameter int FRAMES_ENH   = 18,
    parameter int TIMEOUT_CYC  = 65535
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_SLOTS-1:0]      req,
    input  logic [N_SLOTS-1:0]      fmt,
    input  logic [N_SLOTS-1:0]      cfg,
    input  logic [8*N_SLOTS-1:0]    id_bus,
    input  logic [16*N_SLOTS-1:0]   data_bus,
    input  logic                    frame_done,
    output logic [N_SLOTS-1:0]      grant,
    output logic [N_SLOTS-1:0]      ack,
    output logic                    channel_format,
    output logic                    config_bit,
    output logic [7:0]              id_8bit,
    output logic [15:0]             data_16bit,
    output logic                    enable,
    output logic                    abort,
    output logic [4:0]              frame_cnt,
    output logic                    busy
);

    localparam int PTR_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [PTR_W:0]   NSL       = (PTR_W + 1)'(N_SLOTS);
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(N_SLOTS - 1);
    localparam logic [TMO_W-1:0] TMO_MAX   = TMO_W'(TIMEOUT_CYC);
    // Counter value in the cycle before it would reach TIMEOUT_CYC.
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [4:0]       LAST_SHORT = 5'(FRAMES_SHORT - 1);
    localparam logic [4:0]       LAST_ENH   = 5'(FRAMES_ENH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_START,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [PTR_W-1:0]     r_owner;
    logic [PTR_W-1:0]     r_rr_ptr;
    logic [N_SLOTS-1:0]   r_grant;
    logic                 r_fmt;
    logic                 r_cfg;
    logic [7:0]           r_id;
    logic [15:0]          r_data;
    logic [4:0]           r_frame_cnt;
    logic [TMO_W-1:0]     r_tmo;
    logic                 r_abort;

    logic [PTR_W-1:0]     w_win;
    logic                 w_win_vld;
    logic [PTR_W:0]       w_sum;
    logic [7:0]           w_id_sel;
    logic [15:0]          w_data_sel;
    logic [N_SLOTS-1:0]   w_owner_oh;
    logic [4:0]           w_last_frame;
    logic                 w_final;
    logic                 w_tmo_hit;
    logic                 w_leave;
    logic [PTR_W-1:0]     w_ptr_next;

    assign w_owner_oh   = N_SLOTS'(1) << r_owner;
    assign w_last_frame = r_fmt ? LAST_ENH : LAST_SHORT;
    // The final frame_done takes priority over a timeout in the same cycle.
    assign w_final      = (r_state == ST_RUN) && frame_done && (r_frame_cnt == w_last_frame);
    assign w_tmo_hit    = (r_state == ST_RUN) && !frame_done && (r_tmo >= TMO_LAST);
    assign w_leave      = (r_state == ST_DONE) || w_tmo_hit;
    assign w_ptr_next   = (r_owner == LAST_SLOT) ? '0 : r_owner + PTR_W'(1);

    // Round-robin search: first requesting slot at or above rr_ptr, with wrap.
    always_comb begin
        w_win     = '0;
        w_win_vld = 1'b0;
        w_sum     = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            w_sum = {1'b0, r_rr_ptr} + (PTR_W + 1)'(i);
            if (w_sum >= NSL) begin
                w_sum = w_sum - NSL;
            end
            if (!w_win_vld && req[w_sum[PTR_W-1:0]]) begin
                w_win     = w_sum[PTR_W-1:0];
                w_win_vld = 1'b1;
            end
        end
    end

    // Select the owner's ID and data words from the flat buses.
    always_comb begin
        w_id_sel   = '0;
        w_data_sel = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            if (r_owner == PTR_W'(k)) begin
                w_id_sel   = id_bus[8*k +: 8];
                w_data_sel = data_bus[16*k +: 16];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state and state-decoded outputs.
    always_comb begin
        w_next = r_state;
        enable = 1'b0;
        ack    = '0;
        busy   = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (w_win_vld) begin
                    w_next = ST_GRANT;
                end
            end
            ST_GRANT: w_next = ST_START;
            ST_START: begin
                enable = 1'b1;
                w_next = ST_RUN;
            end
            ST_RUN: begin
                if (w_final) begin
                    w_next = ST_DONE;
                end else if (w_tmo_hit) begin
                    w_next = ST_IDLE;
                end
            end
            ST_DONE: begin
                ack    = r_grant;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Remember the arbitration winner and advance the round-robin pointer past it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_win_vld) begin
                r_owner <= w_win;
            end
            if (w_leave) begin
                r_rr_ptr <= w_ptr_next;
            end
        end
    end

    // Latch the owner's message fields and grant; hold them until the message ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant <= '0;
            r_fmt   <= 1'b0;
            r_cfg   <= 1'b0;
            r_id    <= '0;
            r_data  <= '0;
        end else if (r_state == ST_GRANT) begin
            r_grant <= w_owner_oh;
            r_fmt   <= fmt[r_owner];
            r_cfg   <= cfg[r_owner];
            r_id    <= w_id_sel;
            r_data  <= w_data_sel;
        end else if (w_leave) begin
            r_grant <= '0;
        end
    end

    // Count completed frames and the idle cycles between them (saturating).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_cnt <= '0;
            r_tmo       <= '0;
        end else begin
            if (r_state == ST_GRANT) begin
                r_frame_cnt <= '0;
            end else if ((r_state == ST_RUN) && frame_done) begin
                r_frame_cnt <= r_frame_cnt + 5'd1;
            end
            if ((r_state != ST_RUN) || frame_done) begin
                r_tmo <= '0;
            end else if (r_tmo != TMO_MAX) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end
        end
    end

    // One-cycle abort pulse when the transmitter stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_abort <= 1'b0;
        end else begin
            r_abort <= w_tmo_hit;
        end
    end

    assign grant          = r_grant;
    assign channel_format = r_fmt;
    assign config_bit     = r_cfg;
    assign id_8bit        = r_id;
    assign data_16bit     = r_data;
    assign frame_cnt      = r_frame_cnt;
    assign abort          = r_abort;

endmodule

// File: tb/tb_sent_slow_msg_arbiter.sv
// Testbench for sent_slow_msg_arbiter: directed steps with a scoreboard of
// expected message starts, acks and aborts checked by a negedge monitor.
module tb_sent_slow_msg_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  fmt;
    logic [3:0]  cfg;
    logic [31:0] id_bus;
    logic [63:0] data_bus;
    logic        frame_done;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic        channel_format;
    logic        config_bit;
    logic [7:0]  id_8bit;
    logic [15:0] data_16bit;
    logic        enable;
    logic        abort;
    logic [4:0]  frame_cnt;
    logic        busy;

    sent_slow_msg_arbiter #(
        .N_SLOTS(4),
        .FRAMES_SHORT(16),
        .FRAMES_ENH(18),
        .TIMEOUT_CYC(20)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .fmt(fmt),
        .cfg(cfg),
        .id_bus(id_bus),
        .data_bus(data_bus),
        .frame_done(frame_done),
        .grant(grant),
        .ack(ack),
        .channel_format(channel_format),
        .config_bit(config_bit),
        .id_8bit(id_8bit),
        .data_16bit(data_16bit),
        .enable(enable),
        .abort(abort),
        .frame_cnt(frame_cnt),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  g;
        logic        f;
        logic        c;
        logic [7:0]  id;
        logic [15:0] d;
    } msg_t;

    msg_t       exp_msg_q[$];
    logic [3:0] exp_ack_q[$];
    int         exp_abort_q[$];

    int   ntests = 0;
    int   nfail  = 0;
    int   cyc = 0;
    int   last_ack_cyc = 0;
    bit   pending = 1'b0;
    bit   chk_gap = 1'b0;
    msg_t mon_m;
    logic [3:0] mon_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic msg_t mk(input int s);
        msg_t m;
        m.g  = 4'b0001 << s;
        m.f  = fmt[s];
        m.c  = cfg[s];
        m.id = id_bus[8*s +: 8];
        m.d  = data_bus[16*s +: 16];
        return m;
    endfunction

    // Scoreboard monitor: compare starts, acks and aborts against queued expectations.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            pending = 1'b0;
        end else begin
            if (enable) begin
                chk("enable_expected", 32'(exp_msg_q.size() != 0), 32'd1);
                if (exp_msg_q.size() != 0) begin
                    mon_m = exp_msg_q.pop_front();
                    chk("start_fields", 32'({grant, channel_format, config_bit, id_8bit, data_16bit}), 32'(mon_m));
                end
                chk("frame_cnt_at_start", 32'(frame_cnt), 32'd0);
                chk("ack_before_grant", 32'(pending), 32'd0);
                if (chk_gap) chk("ack_to_enable_gap", 32'(cyc - last_ack_cyc), 32'd3);
                pending = 1'b1;
            end
            if (ack != 4'b0000) begin
                chk("ack_expected", 32'(exp_ack_q.size() != 0), 32'd1);
                if (exp_ack_q.size() != 0) begin
                    mon_a = exp_ack_q.pop_front();
                    chk("ack_value", 32'(ack), 32'(mon_a));
                end
                chk("abort_with_ack", 32'(abort), 32'd0);
                pending = 1'b0;
                last_ack_cyc = cyc;
            end
            if (abort) begin
                chk("abort_expected", 32'(exp_abort_q.size() != 0), 32'd1);
                if (exp_abort_q.size() != 0) void'(exp_abort_q.pop_front());
                chk("grant_at_abort", 32'(grant), 32'd0);
                pending = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
    endtask

    // Wait (bounded) for the start pulse, then move into the RUN cycle.
    task automatic wait_en(input bit drop);
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (enable) seen = 1'b1;
        end
        chk("enable_seen", 32'(seen), 32'd1);
        if (drop) req = 4'b0000;
        step();
    endtask

    // Run a complete message for one slot and check the frame count and ack timing.
    task automatic run_msg(input int slot, input int gap, input bit drop, input bit modbus);
        msg_t       e   = mk(slot);
        int         nfr = fmt[slot] ? 18 : 16;
        logic [3:0] oh  = 4'b0001 << slot;
        logic [63:0] save_data = data_bus;
        logic [31:0] save_id   = id_bus;
        logic [3:0]  save_fmt  = fmt;
        wait_en(drop);
        if (modbus) begin
            data_bus[15:0] = 16'hFFFF;
            id_bus[7:0]    = 8'hEE;
            fmt[0]         = 1'b1;
        end
        for (int k = 0; k < nfr; k++) begin
            if (k == nfr - 1) exp_ack_q.push_back(oh);
            frame();
            chk("frame_cnt", 32'(frame_cnt), 32'(k + 1));
            if (k < nfr - 1) begin
                chk("no_early_ack", 32'(ack), 32'd0);
            end else begin
                chk("ack_after_last", 32'(ack), 32'(oh));
                chk("fields_held", 32'({channel_format, config_bit, id_8bit, data_16bit}), 32'({e.f, e.c, e.id, e.d}));
            end
            repeat (gap) step();
        end
        if (modbus) begin
            data_bus = save_data;
            id_bus   = save_id;
            fmt      = save_fmt;
        end
    endtask

    initial begin
        reset      = 1'b1;
        req        = 4'b0000;
        fmt        = 4'b0100;
        cfg        = 4'b0100;
        id_bus     = {8'h13, 8'hA5, 8'h11, 8'h10};
        data_bus   = {16'hA003, 16'h1234, 16'hA001, 16'hA000};
        frame_done = 1'b0;
        repeat (2) step();

        // Reset state
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_enable", 32'(enable), 32'd0);
        chk("rst_abort", 32'(abort), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_id", 32'(id_8bit), 32'd0);
        chk("rst_data", 32'(data_16bit), 32'd0);
        chk("rst_fmt", 32'(channel_format), 32'd0);
        chk("rst_cfg", 32'(config_bit), 32'd0);
        reset = 1'b0;
        step();

        // Single short message from slot 0; bus/req changes mid-message ignored
        req = 4'b0001;
        exp_msg_q.push_back(mk(0));
        run_msg(0, 1, 1'b1, 1'b1);
        chk("idle_after_ack", 32'(busy), 32'd0);

        // Enhanced message from slot 2
        req = 4'b0100;
        exp_msg_q.push_back(mk(2));
        run_msg(2, 1, 1'b1, 1'b0);

        // Round-robin fairness with all slots requesting, starting from pointer 0
        reset = 1'b1;
        step();
        reset = 1'b0;
        req = 4'b1111;
        exp_msg_q.push_back(mk(0));
        exp_msg_q.push_back(mk(1));
        exp_msg_q.push_back(mk(2));
        exp_msg_q.push_back(mk(3));
        exp_msg_q.push_back(mk(0));
        run_msg(0, 1, 1'b0, 1'b0);
        chk_gap = 1'b1;
        run_msg(1, 1, 1'b0, 1'b0);
        run_msg(2, 1, 1'b0, 1'b0);
        run_msg(3, 1, 1'b0, 1'b0);
        run_msg(0, 1, 1'b1, 1'b0);
        chk_gap = 1'b0;

        // Timeout: slot 1 stalls after 3 frames, channel then goes to slot 2
        req = 4'b0110;
        exp_msg_q.push_back(mk(1));
        exp_abort_q.push_back(1);
        exp_msg_q.push_back(mk(2));
        wait_en(1'b0);
        for (int k = 0; k < 3; k++) begin
            frame();
            chk("tmo_frame_cnt", 32'(frame_cnt), 32'(k + 1));
            if (k < 2) step();
        end
        for (int c = 1; c <= 20; c++) begin
            step();
            if (c == 19) begin
                chk("tmo_abort_early", 32'(abort), 32'd0);
                chk("tmo_busy_early", 32'(busy), 32'd1);
            end
            if (c == 20) begin
                chk("tmo_abort", 32'(abort), 32'd1);
                chk("tmo_grant_clear", 32'(grant), 32'd0);
                chk("tmo_no_ack", 32'(ack), 32'd0);
                chk("tmo_idle", 32'(busy), 32'd0);
            end
        end
        step();
        chk("tmo_abort_single", 32'(abort), 32'd0);
        run_msg(2, 1, 1'b1, 1'b0);

        // Final frame_done coincides with the timeout threshold
        req = 4'b1000;
        exp_msg_q.push_back(mk(3));
        wait_en(1'b1);
        for (int k = 0; k < 15; k++) begin
            frame();
            if (k < 14) step();
        end
        chk("coin_frame_cnt", 32'(frame_cnt), 32'd15);
        repeat (19) step();
        exp_ack_q.push_back(4'b1000);
        frame();
        chk("coin_ack", 32'(ack), 32'b1000);
        chk("coin_no_abort", 32'(abort), 32'd0);
        step();
        chk("coin_no_abort_next", 32'(abort), 32'd0);

        // Reset in the middle of a message
        req = 4'b0001;
        exp_msg_q.push_back(mk(0));
        wait_en(1'b1);
        for (int k = 0; k < 7; k++) begin
            frame();
            step();
        end
        chk("mid_frame_cnt", 32'(frame_cnt), 32'd7);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_ack", 32'(ack), 32'd0);
        chk("mid_rst_abort", 32'(abort), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("mid_rst_fields", 32'({channel_format, config_bit, id_8bit, data_16bit}), 32'd0);
        step();
        chk("mid_rst_enable", 32'(enable), 32'd0);
        reset = 1'b0;
        req = 4'b0010;
        exp_msg_q.push_back(mk(1));
        run_msg(1, 1, 1'b1, 1'b0);
        repeat (4) step();

        chk("msg_q_empty", 32'(exp_msg_q.size()), 32'd0);
        chk("ack_q_empty", 32'(exp_ack_q.size()), 32'd0);
        chk("abort_q_empty", 32'(exp_abort_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
